// File: rtl/artifact_pattgen.sv
// Pixel-rate stripe test source for the artifact-colour path: raster counters, syncs, per-frame mode latch.
// Optional `ARTIPAT_BORDER_EN forces a 255 frame around the active area.
module artifact_pattgen #(
  parameter int H_ACTIVE = 384,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_TOTAL  = 456,
  parameter int V_ACTIVE = 240,
  parameter int V_SS     = 244,
  parameter int V_SW     = 3,
  parameter int V_TOTAL  = 262
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic [1:0] mode,
  input  logic [7:0] fg_level,
  input  logic [7:0] bg_level,
  input  logic       frame_swap,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hbl_out,
  output logic       vbl_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic [7:0] frame_cnt
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HA  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HAL = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HSB = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSE = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HL  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VAL = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VSB = VW'(V_SS);
  localparam logic [VW-1:0] VSE = VW'(V_SS + V_SW);
  localparam logic [VW-1:0] VL  = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [7:0]    r_frame;
  logic [1:0]    r_mode_l;
  logic [7:0]    r_fg_l, r_bg_l;
  logic          r_swap_l;
  logic [7:0]    r_pix;
  logic          r_hbl, r_vbl, r_hs, r_vs;

  logic          w_h_last, w_v_last, w_sof;
  logic [1:0]    w_mode;
  logic [7:0]    w_fg, w_bg, w_level;
  logic          w_swap, w_phase, w_on, w_hbl, w_vbl, w_hs, w_vs;

  assign w_h_last = (r_hcnt == HL);
  assign w_v_last = (r_vcnt == VL);
  assign w_sof    = (r_hcnt == '0) && (r_vcnt == '0);

  // The frame-start pixel already uses the values being latched on this ce_pix.
  assign w_mode  = w_sof ? mode       : r_mode_l;
  assign w_fg    = w_sof ? fg_level   : r_fg_l;
  assign w_bg    = w_sof ? bg_level   : r_bg_l;
  assign w_swap  = w_sof ? frame_swap : r_swap_l;
  assign w_phase = w_swap & r_frame[0];

  assign w_hbl = (r_hcnt >= HA);
  assign w_vbl = (r_vcnt >= VA);
  assign w_hs  = (r_hcnt >= HSB) && (r_hcnt < HSE);
  assign w_vs  = (r_vcnt >= VSB) && (r_vcnt < VSE);

  always_comb begin
    w_on = 1'b0;
    case (w_mode)
      2'd0: w_on = 1'b0;
      2'd1: w_on = r_hcnt[0] ^ w_phase;
      2'd2: w_on = r_hcnt[1] ^ w_phase;
      2'd3: w_on = r_hcnt[0] ^ w_phase ^ r_vcnt[4];
      default: w_on = 1'b0;
    endcase
  end

  always_comb begin
    w_level = w_on ? w_fg : w_bg;
`ifdef ARTIPAT_BORDER_EN
    if ((r_hcnt == '0) || (r_hcnt == HAL) || (r_vcnt == '0) || (r_vcnt == VAL))
      w_level = 8'd255;
`endif
    if (w_hbl || w_vbl)
      w_level = 8'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_frame <= '0;
    end else if (ce_pix) begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
      if (w_h_last) begin
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        if (w_v_last)
          r_frame <= r_frame + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_l <= '0;
      r_fg_l   <= '0;
      r_bg_l   <= '0;
      r_swap_l <= 1'b0;
    end else if (ce_pix && w_sof) begin
      r_mode_l <= mode;
      r_fg_l   <= fg_level;
      r_bg_l   <= bg_level;
      r_swap_l <= frame_swap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix <= '0;
      r_hbl <= 1'b1;
      r_vbl <= 1'b1;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else if (ce_pix) begin
      r_pix <= w_level;
      r_hbl <= w_hbl;
      r_vbl <= w_vbl;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
    end
  end

  assign r_out     = r_pix;
  assign g_out     = r_pix;
  assign b_out     = r_pix;
  assign hbl_out   = r_hbl;
  assign vbl_out   = r_vbl;
  assign hs_out    = r_hs;
  assign vs_out    = r_vs;
  assign frame_cnt = r_frame;
endmodule
